// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                  |
// | Description : Two-port arbiter/sequencer in front of the shared ALU.       |
// |               Accepts one request per transaction over valid/ready, drives |
// |               the ALU from registered operands, captures result and zero   |
// |               flag, and returns them over the winner's response handshake. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n              clock, asynchronous active-low reset             |
// |   reqN_valid/ready        request handshake, N = 0,1 (ready only in IDLE)  |
// |   reqN_a, reqN_b, reqN_op request operands and opcode                      |
// |   respN_valid/ready       response handshake for the granted port          |
// |   resp_r, resp_z          captured result and zero flag (shared)           |
// |   resp_err                opcode was >= NOPS                               |
// |   alu_a, alu_b, alu_op    ALU drive, always from the operand registers     |
// |   alu_r, alu_isz          ALU result and zero flag                         |
// | Configuration                                                              |
// |   ALU_ARB_RR_EN           defined: round-robin on contention               |
// |                           undefined: port 0 has fixed priority             |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int          WIDTH = 32,
  parameter int unsigned NOPS  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_r,
  output logic             resp_z,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_isz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             gid_q, gid_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             z_q, z_d;
  logic             err_q, err_d;
`ifdef ALU_ARB_RR_EN
  logic             last_q, last_d;
`endif

  logic gnt_any;
  logic gnt_id;
  logic resp_hs;

  // Winner among the currently valid requests; only meaningful when gnt_any.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
`ifdef ALU_ARB_RR_EN
    // On contention the port that did not win last time goes next.
    gnt_id  = req0_valid ? (req1_valid ? ~last_q : 1'b0) : 1'b1;
`else
    gnt_id  = ~req0_valid;
`endif
  end

  // rst_n gating keeps ready low while reset is held, even with a valid present.
  assign req0_ready  = rst_n && (state_q == IDLE) && gnt_any && !gnt_id;
  assign req1_ready  = rst_n && (state_q == IDLE) && gnt_any &&  gnt_id;

  assign resp0_valid = (state_q == RESP) && !gid_q;
  assign resp1_valid = (state_q == RESP) &&  gid_q;
  assign resp_hs     = gid_q ? resp1_ready : resp0_ready;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign resp_r   = r_q;
  assign resp_z   = z_q;
  assign resp_err = err_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    gid_d   = gid_q;
    r_d     = r_q;
    z_d     = z_q;
    err_d   = err_q;
`ifdef ALU_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          op_d    = gnt_id ? req1_op : req0_op;
          gid_d   = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Illegal opcodes never expose whatever the ALU produced for them.
        if (32'(op_q) >= NOPS) begin
          r_d   = '0;
          z_d   = 1'b1;
          err_d = 1'b1;
        end else begin
          r_d   = alu_r;
          z_d   = alu_isz;
          err_d = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
`ifdef ALU_ARB_RR_EN
          last_d  = gid_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      gid_q   <= 1'b0;
      r_q     <= '0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      gid_q   <= gid_d;
      r_q     <= r_d;
      z_q     <= z_d;
      err_q   <= err_d;
`ifdef ALU_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
`default_nettype wire
